// File: rtl/addsub_serial_if.sv
// Operand/result bus of the digit-serial adder/subtractor.
//   i_start, i_a, i_b, i_sub, i_cin : request side, driven by the master
//   o_busy, o_done                  : operation status, driven by the slave
//   o_result, o_cout, o_ovf, o_zero : registered result and flags, driven by the slave
interface addsub_serial_if #(
  parameter int unsigned WIDTH = 32
);
  logic             i_start;
  logic [WIDTH-1:0] i_a;
  logic [WIDTH-1:0] i_b;
  logic             i_sub;
  logic             i_cin;
  logic             o_busy;
  logic             o_done;
  logic [WIDTH-1:0] o_result;
  logic             o_cout;
  logic             o_ovf;
  logic             o_zero;

  modport master (
    output i_start, i_a, i_b, i_sub, i_cin,
    input  o_busy, o_done, o_result, o_cout, o_ovf, o_zero
  );

  modport slave (
    input  i_start, i_a, i_b, i_sub, i_cin,
    output o_busy, o_done, o_result, o_cout, o_ovf, o_zero
  );
endinterface

// File: rtl/addsub_serial.sv
// Digit-serial adder/subtractor: CHUNK bits per clock, LSB chunk first, N = WIDTH/CHUNK cycles.
// Ports:
//   i_clk : clock, rising edge
//   i_rst : asynchronous active-high reset
//   bus   : addsub_serial_if slave (start/operands in, busy/done/result/flags out)
// Subtraction is A + ~B + ~borrow; o_cout is the raw MSB carry (1 = no borrow when subtracting).
// Result and flags update only when DONE is entered (or on reset).
module addsub_serial #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8
) (
  input logic            i_clk,
  input logic            i_rst,
  addsub_serial_if.slave bus
);

  localparam int unsigned N     = WIDTH / CHUNK;
  localparam int unsigned CNT_W = $clog2(N) + 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             carry_q, carry_d;
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  logic [CHUNK:0]   chunk_sum;
  logic [WIDTH-1:0] acc_next;
  logic             last;
  logic             load;

  // Operands shift right each cycle, so the current chunk is always at bit 0.
  assign chunk_sum = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]} + {{CHUNK{1'b0}}, carry_q};
  // Result chunks enter at the top and shift down; after N cycles chunk 0 sits at bit 0.
  assign acc_next  = (acc_q >> CHUNK) | (WIDTH'(chunk_sum[CHUNK-1:0]) << (WIDTH - CHUNK));
  assign last      = (cnt_q == CNT_W'(N - 1));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    carry_d  = carry_q;
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;
    load     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.i_start) load = 1'b1;
      end
      StRun: begin
        a_d     = a_q >> CHUNK;
        b_d     = b_q >> CHUNK;
        acc_d   = acc_next;
        carry_d = chunk_sum[CHUNK];
        cnt_d   = cnt_q + CNT_W'(1);
        if (last) begin
          state_d  = StDone;
          result_d = acc_next;
          cout_d   = chunk_sum[CHUNK];
          ovf_d    = (a_msb_q == b_msb_q) && (acc_next[WIDTH-1] != a_msb_q);
          zero_d   = (acc_next == '0);
        end
      end
      StDone: begin
        state_d = StIdle;
        if (bus.i_start) load = 1'b1;
      end
      default: state_d = StIdle;
    endcase

    if (load) begin
      state_d = StRun;
      cnt_d   = '0;
      acc_d   = '0;
      a_d     = bus.i_a;
      b_d     = bus.i_sub ? ~bus.i_b : bus.i_b;
      carry_d = bus.i_sub ^ bus.i_cin;
      a_msb_d = bus.i_a[WIDTH-1];
      b_msb_d = bus.i_sub ? ~bus.i_b[WIDTH-1] : bus.i_b[WIDTH-1];
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      carry_q  <= 1'b0;
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      carry_q  <= carry_d;
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
    end
  end

  assign bus.o_busy   = (state_q == StRun);
  assign bus.o_done   = (state_q == StDone);
  assign bus.o_result = result_q;
  assign bus.o_cout   = cout_q;
  assign bus.o_ovf    = ovf_q;
  assign bus.o_zero   = zero_q;

endmodule

// File: tb/tb_addsub_serial.sv
// Self-checking bench for addsub_serial in three configurations: (32,8), (32,32), (16,1).
module tb_addsub_serial;

  logic i_clk;
  logic i_rst;

  addsub_serial_if #(.WIDTH(32)) if0 ();
  addsub_serial_if #(.WIDTH(32)) if1 ();
  addsub_serial_if #(.WIDTH(16)) if2 ();

  addsub_serial #(.WIDTH(32), .CHUNK(8))  u_dut0 (.i_clk(i_clk), .i_rst(i_rst), .bus(if0));
  addsub_serial #(.WIDTH(32), .CHUNK(32)) u_dut1 (.i_clk(i_clk), .i_rst(i_rst), .bus(if1));
  addsub_serial #(.WIDTH(16), .CHUNK(1))  u_dut2 (.i_clk(i_clk), .i_rst(i_rst), .bus(if2));

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model, computed arithmetically on masked operands.
  task automatic golden(input int w, input logic [31:0] a, input logic [31:0] b,
                        input logic sub, input logic cin,
                        output logic [31:0] r, output logic co, output logic ov, output logic z);
    logic [32:0] mask;
    logic [32:0] s;
    logic        sa, sb, sr;
    mask = (33'd1 << w) - 33'd1;
    sa   = a[w-1];
    sb   = b[w-1];
    if (!sub) begin
      s  = {1'b0, a} + {1'b0, b} + {32'd0, cin};
      r  = s[31:0] & mask[31:0];
      co = s[w];
      sr = r[w-1];
      ov = (sa == sb) && (sr != sa);
    end else begin
      r  = (a - b - {31'd0, cin}) & mask[31:0];
      co = ({1'b0, a} >= ({1'b0, b} + {32'd0, cin}));
      sr = r[w-1];
      ov = (sa != sb) && (sr != sa);
    end
    z = (r == 32'd0);
  endtask

  task automatic expect_op(input string tag, input logic [31:0] r, input logic co,
                           input logic ov, input logic z, input int lat, input logic busy_ok,
                           input logic [31:0] er, input logic eco, input logic eov,
                           input logic ez, input int elat);
    check({tag, " result"}, 64'(r), 64'(er));
    check({tag, " cout"}, 64'(co), 64'(eco));
    check({tag, " ovf"}, 64'(ov), 64'(eov));
    check({tag, " zero"}, 64'(z), 64'(ez));
    check({tag, " latency"}, 64'(lat), 64'(elat));
    check({tag, " busy"}, 64'(busy_ok), 64'(1));
  endtask

  task automatic check_op(input string tag, input int w, input int n,
                          input logic [31:0] a, input logic [31:0] b, input logic sub,
                          input logic cin, input logic [31:0] r, input logic co,
                          input logic ov, input logic z, input int lat, input logic busy_ok);
    logic [31:0] er;
    logic        eco, eov, ez;
    string       t;
    golden(w, a, b, sub, cin, er, eco, eov, ez);
    t = $sformatf("%s a=%h b=%h sub=%0d cin=%0d", tag, a, b, sub, cin);
    expect_op(t, r, co, ov, z, lat, busy_ok, er, eco, eov, ez, n);
  endtask

  // Each op task starts from #1 after an edge with the DUT in IDLE or DONE and returns
  // #1 after the edge where o_done is seen (or the bound expires).
  task automatic op0(input logic [31:0] a, input logic [31:0] b, input logic sub,
                     input logic cin, output logic [31:0] r, output logic co,
                     output logic ov, output logic z, output int lat, output logic busy_ok);
    if0.i_a = a; if0.i_b = b; if0.i_sub = sub; if0.i_cin = cin; if0.i_start = 1'b1;
    @(posedge i_clk); #1;
    if0.i_start = 1'b0;
    lat = 0; busy_ok = 1'b1;
    while (!if0.o_done && lat < 64) begin
      if (!if0.o_busy) busy_ok = 1'b0;
      @(posedge i_clk); #1;
      lat++;
    end
    if (if0.o_busy) busy_ok = 1'b0;
    r = if0.o_result; co = if0.o_cout; ov = if0.o_ovf; z = if0.o_zero;
  endtask

  task automatic op1(input logic [31:0] a, input logic [31:0] b, input logic sub,
                     input logic cin, output logic [31:0] r, output logic co,
                     output logic ov, output logic z, output int lat, output logic busy_ok);
    if1.i_a = a; if1.i_b = b; if1.i_sub = sub; if1.i_cin = cin; if1.i_start = 1'b1;
    @(posedge i_clk); #1;
    if1.i_start = 1'b0;
    lat = 0; busy_ok = 1'b1;
    while (!if1.o_done && lat < 64) begin
      if (!if1.o_busy) busy_ok = 1'b0;
      @(posedge i_clk); #1;
      lat++;
    end
    if (if1.o_busy) busy_ok = 1'b0;
    r = if1.o_result; co = if1.o_cout; ov = if1.o_ovf; z = if1.o_zero;
  endtask

  task automatic op2(input logic [31:0] a, input logic [31:0] b, input logic sub,
                     input logic cin, output logic [31:0] r, output logic co,
                     output logic ov, output logic z, output int lat, output logic busy_ok);
    if2.i_a = a[15:0]; if2.i_b = b[15:0]; if2.i_sub = sub; if2.i_cin = cin;
    if2.i_start = 1'b1;
    @(posedge i_clk); #1;
    if2.i_start = 1'b0;
    lat = 0; busy_ok = 1'b1;
    while (!if2.o_done && lat < 64) begin
      if (!if2.o_busy) busy_ok = 1'b0;
      @(posedge i_clk); #1;
      lat++;
    end
    if (if2.o_busy) busy_ok = 1'b0;
    r = 32'(if2.o_result); co = if2.o_cout; ov = if2.o_ovf; z = if2.o_zero;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r, a, b;
    logic        co, ov, z, busy_ok, sub, cin, seen_done;
    int          lat;

    i_rst = 1'b1;
    if0.i_start = 1'b0; if0.i_a = '0; if0.i_b = '0; if0.i_sub = 1'b0; if0.i_cin = 1'b0;
    if1.i_start = 1'b0; if1.i_a = '0; if1.i_b = '0; if1.i_sub = 1'b0; if1.i_cin = 1'b0;
    if2.i_start = 1'b0; if2.i_a = '0; if2.i_b = '0; if2.i_sub = 1'b0; if2.i_cin = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    @(posedge i_clk); #1;

    // Reset state
    check("reset result", 64'(if0.o_result), 64'h0);
    check("reset busy", 64'(if0.o_busy), 64'h0);
    check("reset done", 64'(if0.o_done), 64'h0);
    check("reset cout", 64'(if0.o_cout), 64'h0);
    check("reset ovf", 64'(if0.o_ovf), 64'h0);
    check("reset zero", 64'(if0.o_zero), 64'h0);

    // Directed vectors, (32,8)
    op0(32'h5, 32'h3, 1'b0, 1'b0, r, co, ov, z, lat, busy_ok);
    expect_op("add 5+3", r, co, ov, z, lat, busy_ok, 32'h8, 1'b0, 1'b0, 1'b0, 4);
    op0(32'h5, 32'h5, 1'b1, 1'b0, r, co, ov, z, lat, busy_ok);
    expect_op("sub 5-5", r, co, ov, z, lat, busy_ok, 32'h0, 1'b1, 1'b0, 1'b1, 4);
    op0(32'h0, 32'h1, 1'b1, 1'b0, r, co, ov, z, lat, busy_ok);
    expect_op("sub 0-1", r, co, ov, z, lat, busy_ok, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 4);
    op0(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, r, co, ov, z, lat, busy_ok);
    expect_op("add ovf", r, co, ov, z, lat, busy_ok, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 4);
    op0(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, r, co, ov, z, lat, busy_ok);
    expect_op("add wrap", r, co, ov, z, lat, busy_ok, 32'h0, 1'b1, 1'b0, 1'b1, 4);
    op0(32'h3, 32'h5, 1'b1, 1'b1, r, co, ov, z, lat, busy_ok);
    expect_op("sub 3-5-1", r, co, ov, z, lat, busy_ok, 32'hFFFF_FFFD, 1'b0, 1'b0, 1'b0, 4);

    // DONE lasts one cycle; result held in IDLE
    @(posedge i_clk); #1;
    check("done pulse width", 64'(if0.o_done), 64'h0);
    check("idle busy", 64'(if0.o_busy), 64'h0);
    check("idle hold result", 64'(if0.o_result), 64'hFFFF_FFFD);
    @(posedge i_clk); #1;

    // i_start mid-RUN with new operands is ignored
    if0.i_a = 32'h10; if0.i_b = 32'h20; if0.i_sub = 1'b0; if0.i_cin = 1'b0;
    if0.i_start = 1'b1;
    @(posedge i_clk); #1;
    if0.i_start = 1'b0;
    lat = 0;
    check("run hold result", 64'(if0.o_result), 64'hFFFF_FFFD);
    while (!if0.o_done && lat < 64) begin
      @(posedge i_clk); #1;
      lat++;
      if (lat == 1) begin
        if0.i_a = 32'hFFFF_0000; if0.i_b = 32'h1; if0.i_sub = 1'b1; if0.i_start = 1'b1;
      end else begin
        if0.i_start = 1'b0;
      end
    end
    if0.i_start = 1'b0;
    check("midrun latency", 64'(lat), 64'd4);
    check("midrun result", 64'(if0.o_result), 64'h30);
    @(posedge i_clk); #1;
    check("midrun no restart", 64'(if0.o_busy), 64'h0);

    // Back-to-back: start held in the DONE cycle
    op0(32'h1, 32'h2, 1'b0, 1'b0, r, co, ov, z, lat, busy_ok);
    expect_op("b2b first", r, co, ov, z, lat, busy_ok, 32'h3, 1'b0, 1'b0, 1'b0, 4);
    op0(32'd100, 32'd200, 1'b0, 1'b0, r, co, ov, z, lat, busy_ok);
    expect_op("b2b second", r, co, ov, z, lat, busy_ok, 32'd300, 1'b0, 1'b0, 1'b0, 4);
    @(posedge i_clk); #1;

    // Reset during RUN cycle 2 aborts
    op0(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, r, co, ov, z, lat, busy_ok);
    if0.i_a = 32'h1; if0.i_b = 32'h1; if0.i_start = 1'b1;
    @(posedge i_clk); #1;
    if0.i_start = 1'b0;
    repeat (2) @(posedge i_clk);
    #2;
    i_rst = 1'b1;
    #1;
    check("abort result", 64'(if0.o_result), 64'h0);
    check("abort busy", 64'(if0.o_busy), 64'h0);
    check("abort done", 64'(if0.o_done), 64'h0);
    check("abort ovf", 64'(if0.o_ovf), 64'h0);
    check("abort cout", 64'(if0.o_cout), 64'h0);
    @(negedge i_clk);
    i_rst = 1'b0;
    seen_done = 1'b0;
    repeat (8) begin
      @(posedge i_clk); #1;
      if (if0.o_done || if0.o_busy) seen_done = 1'b1;
    end
    check("abort no done", 64'(seen_done), 64'h0);
    op0(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, r, co, ov, z, lat, busy_ok);
    expect_op("post reset", r, co, ov, z, lat, busy_ok, 32'h2345_6789, 1'b0, 1'b0, 1'b0, 4);

    // Directed vectors, (32,32) and (16,1)
    op1(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, r, co, ov, z, lat, busy_ok);
    expect_op("w32c32 ovf", r, co, ov, z, lat, busy_ok, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1);
    op1(32'h3, 32'h5, 1'b1, 1'b1, r, co, ov, z, lat, busy_ok);
    expect_op("w32c32 sub", r, co, ov, z, lat, busy_ok, 32'hFFFF_FFFD, 1'b0, 1'b0, 1'b0, 1);
    op2(32'h7FFF, 32'h0, 1'b0, 1'b1, r, co, ov, z, lat, busy_ok);
    expect_op("w16c1 ovf", r, co, ov, z, lat, busy_ok, 32'h8000, 1'b0, 1'b1, 1'b0, 16);
    op2(32'h8000, 32'h1, 1'b1, 1'b0, r, co, ov, z, lat, busy_ok);
    expect_op("w16c1 sub", r, co, ov, z, lat, busy_ok, 32'h7FFF, 1'b1, 1'b1, 1'b0, 16);
    op2(32'hFFFF, 32'h0, 1'b0, 1'b1, r, co, ov, z, lat, busy_ok);
    expect_op("w16c1 wrap", r, co, ov, z, lat, busy_ok, 32'h0, 1'b1, 1'b0, 1'b1, 16);

    // Random regression against the reference model
    for (int i = 0; i < 2000; i++) begin
      a = $urandom; b = $urandom; sub = 1'($urandom); cin = 1'($urandom);
      if ($urandom_range(3, 0) == 0) begin @(posedge i_clk); #1; end
      op0(a, b, sub, cin, r, co, ov, z, lat, busy_ok);
      check_op("rnd w32c8", 32, 4, a, b, sub, cin, r, co, ov, z, lat, busy_ok);
    end
    for (int i = 0; i < 400; i++) begin
      a = $urandom; b = $urandom; sub = 1'($urandom); cin = 1'($urandom);
      if ($urandom_range(3, 0) == 0) begin @(posedge i_clk); #1; end
      op1(a, b, sub, cin, r, co, ov, z, lat, busy_ok);
      check_op("rnd w32c32", 32, 1, a, b, sub, cin, r, co, ov, z, lat, busy_ok);
    end
    for (int i = 0; i < 300; i++) begin
      a = {16'h0, 16'($urandom)}; b = {16'h0, 16'($urandom)};
      sub = 1'($urandom); cin = 1'($urandom);
      if ($urandom_range(3, 0) == 0) begin @(posedge i_clk); #1; end
      op2(a, b, sub, cin, r, co, ov, z, lat, busy_ok);
      check_op("rnd w16c1", 16, 16, a, b, sub, cin, r, co, ov, z, lat, busy_ok);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
